qspi_xfer_engine: RTL
=====================

// Module: qspi_xfer_engine
// PURPOSE
//   Parametrised QSPI transfer engine succeeding the fixed flash/RAM SPI master.
//   Runs one programmable transaction per start: optional command, address, mode byte, dummy, data phases.
//   Adds an SCK divider, per-phase single/quad width, NUM_CS chip selects, byte-granular length and abort.
//   Sits between the memory/peripheral bus adapters and the QSPI pads.
// PARAMETERS
//   NUM_CS       2   number of chip-select lines (>=1)
//   MAX_BYTES    4   max data bytes per transaction; rdata/wdata are 8*MAX_BYTES wide
//   DIV_W        4   width of clk_div; SCK period = 2*(clk_div+1) clk cycles
//   CS_IDLE      4   min clk cycles CS stays high after a transaction before busy drops
// PORTS
//   clk        in   1              system clock
//   rst_n      in   1              async active-low reset
//   start      in   1              1-cycle request; sampled only when busy==0
//   abort      in   1              force-terminate current transaction
//   cs_sel     in   $clog2(NUM_CS) (min 1)  chip select index
//   clk_div    in   DIV_W          SCK divider, latched at start
//   cmd_en     in   1              send command phase
//   cmd_quad   in   1              1: cmd on IO[3:0] (2 SCK), 0: on IO0 (8 SCK)
//   cmd        in   8              command byte
//   addr_en    in   1              send 24-bit address, always quad (6 SCK)
//   addr       in   24             address, MSB first
//   mode_en    in   1              send mode byte, quad (2 SCK)
//   mode_byte  in   8              mode byte (e.g. 8'hA0 continuous-read)
//   dummy_cyc  in   5              dummy SCK cycles, IO released (0 = none)
//   write      in   1              1: data phase drives, 0: data phase samples
//   nbytes     in   $clog2(MAX_BYTES+1)  data bytes, quad (2 SCK/byte); 0 = no data phase
//   wdata      in   8*MAX_BYTES    write data; first byte sent = wdata[8*nbytes-1 -: 8]
//   rdata      out  8*MAX_BYTES    read data, right-aligned, first byte received most significant
//   busy       out  1              high from cycle after accepted start until CS_IDLE elapsed
//   done       out  1              1-cycle pulse when transaction completes (not on abort)
//   spi_clk    out  1              SCK, mode 0 (idle low)
//   spi_cs_n   out  NUM_CS         chip selects, active low, one-hot-low
//   spi_io_in  in   4              IO input
//   spi_io_out out  4              IO output
//   spi_io_oe  out  4              IO output enable (1 = drive)
// BEHAVIOUR
//   Reset: spi_clk=0, spi_cs_n=all 1, spi_io_out=0, spi_io_oe=0, rdata=0, busy=0, done=0, FSM IDLE.
//   All inputs except abort latched on accepted start; start while busy is ignored.
//   FSM: IDLE->CMD->ADDR->MODE->DUMMY->DATA->CSHOLD->IDLE; disabled/zero-length phases skipped.
//   Start cycle: cs_n[cs_sel] low next cycle; first output nibble/bit valid before first SCK rise.
//   SCK: half-period = clk_div+1 clk cycles; outputs change on SCK fall, inputs sampled on SCK rise.
//   Single-bit cmd: IO0 driven, oe=4'b0001; quad phases oe=4'b1111; DUMMY and read DATA oe=0.
//   Read: each sample shifts rdata left 4 bits; rdata upper bits cleared at start.
//   Last SCK fall after final phase -> CS high, SCK low, oe=0; done pulses that cycle; then CSHOLD
//     holds CS high CS_IDLE cycles, busy drops entering IDLE (new start accepted then).
//   All phases disabled and nbytes=0: CS pulses low for one SCK period, then done.
//   abort (any state): next cycle CS high, SCK low, oe=0, enter CSHOLD; no done; rdata keeps partial.
//   abort with start in same cycle while idle: abort wins, start dropped.
//   Async reset mid-transaction returns all outputs to reset values immediately.
// TESTING
//   Quad read: cmd_en,!cmd_quad,cmd=EB,addr=123456,mode A0,dummy=4,nbytes=4,clk_div=0, flash model
//     returns DEADBEEF -> 8+6+2+4+8 SCK, rdata=DEADBEEF, one done pulse, CS high after.
//   Quad write: cmd_quad,cmd=38,addr=000010,nbytes=2,wdata=..A55A -> IO nibbles 3,8,0,0,0,0,1,0,A,5,5,A.
//   clk_div=3 -> SCK high/low 4 clk each; nbytes=1 read of 0x7E -> rdata=0000007E.
//   cs_sel=1, NUM_CS=2 -> only spi_cs_n[1] toggles; spi_cs_n[0] stays 1 throughout.
//   abort during DATA after 2 SCK -> CS high next cycle, no done, busy low after CS_IDLE; start then accepted.
//   start during busy ignored; start in IDLE cycle right after CSHOLD accepted with CS low next cycle.

Source files
------------

// File: rtl/qspi_xfer_if.sv
// Request, status and pad signals of the QSPI transfer engine.
// The master side is the bus adapter plus flash pads; the slave side is the engine.
interface qspi_xfer_if #(
  parameter int NUM_CS    = 2,
  parameter int MAX_BYTES = 4,
  parameter int DIV_W     = 4
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int NB_W = $clog2(MAX_BYTES + 1);
  localparam int RD_W = 8 * MAX_BYTES;

  logic              start;
  logic              abort;
  logic [CS_W-1:0]   cs_sel;
  logic [DIV_W-1:0]  clk_div;
  logic              cmd_en;
  logic              cmd_quad;
  logic [7:0]        cmd;
  logic              addr_en;
  logic [23:0]       addr;
  logic              mode_en;
  logic [7:0]        mode_byte;
  logic [4:0]        dummy_cyc;
  logic              write;
  logic [NB_W-1:0]   nbytes;
  logic [RD_W-1:0]   wdata;
  logic [RD_W-1:0]   rdata;
  logic              busy;
  logic              done;
  logic              spi_clk;
  logic [NUM_CS-1:0] spi_cs_n;
  logic [3:0]        spi_io_in;
  logic [3:0]        spi_io_out;
  logic [3:0]        spi_io_oe;

  modport master (
    output start, abort, cs_sel, clk_div, cmd_en, cmd_quad, cmd, addr_en, addr,
           mode_en, mode_byte, dummy_cyc, write, nbytes, wdata, spi_io_in,
    input  rdata, busy, done, spi_clk, spi_cs_n, spi_io_out, spi_io_oe
  );

  modport slave (
    input  start, abort, cs_sel, clk_div, cmd_en, cmd_quad, cmd, addr_en, addr,
           mode_en, mode_byte, dummy_cyc, write, nbytes, wdata, spi_io_in,
    output rdata, busy, done, spi_clk, spi_cs_n, spi_io_out, spi_io_oe
  );
endinterface

// File: rtl/qspi_xfer_engine.sv
// QSPI transfer engine: one programmable cmd/addr/mode/dummy/data transaction per start,
// SPI mode 0 with a programmable SCK divider, abort and a CS idle hold-off.
module qspi_xfer_engine #(
  parameter int NUM_CS    = 2,
  parameter int MAX_BYTES = 4,
  parameter int DIV_W     = 4,
  parameter int CS_IDLE   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  qspi_xfer_if.slave  bus
);
  localparam int NB_W   = $clog2(MAX_BYTES + 1);
  localparam int RD_W   = 8 * MAX_BYTES;
  localparam int SR_W   = (RD_W > 32) ? RD_W : 32;
  localparam int HOLD_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, CSHOLD} state_t;

  state_t            state, tgt;
  logic [DIV_W-1:0]  div_q, cnt;
  logic              sck, quiet, quad;
  logic [7:0]        left;
  logic [SR_W-1:0]   sr, sh_sr, ld_sr;
  logic [HOLD_W-1:0] hold;
  logic              cmd_en_q, addr_en_q, mode_en_q, cmd_quad_q, write_q;
  logic [7:0]        cmd_q, mode_q;
  logic [23:0]       addr_q;
  logic [4:0]        dummy_q;
  logic [NB_W-1:0]   nbytes_q;
  logic [RD_W-1:0]   wdata_q;

  // Phase parameters come straight from the request while idle, from the latched copy otherwise.
  logic              idle, s_cmd_en, s_addr_en, s_mode_en, s_cmd_quad, s_write;
  logic [7:0]        s_cmd, s_mode;
  logic [23:0]       s_addr;
  logic [4:0]        s_dummy;
  logic [NB_W-1:0]   s_nbytes;
  logic [RD_W-1:0]   s_wdata;
  logic [4:0]        en;
  logic [7:0]        ld_len;
  logic              ld_quad;
  logic [3:0]        ld_oe, ld_io, sh_io;

  assign idle       = (state == IDLE);
  assign s_cmd_en   = idle ? bus.cmd_en    : cmd_en_q;
  assign s_addr_en  = idle ? bus.addr_en   : addr_en_q;
  assign s_mode_en  = idle ? bus.mode_en   : mode_en_q;
  assign s_cmd_quad = idle ? bus.cmd_quad  : cmd_quad_q;
  assign s_write    = idle ? bus.write     : write_q;
  assign s_cmd      = idle ? bus.cmd       : cmd_q;
  assign s_mode     = idle ? bus.mode_byte : mode_q;
  assign s_addr     = idle ? bus.addr      : addr_q;
  assign s_dummy    = idle ? bus.dummy_cyc : dummy_q;
  assign s_nbytes   = idle ? bus.nbytes    : nbytes_q;
  assign s_wdata    = idle ? bus.wdata     : wdata_q;
  assign en         = {s_nbytes != '0, s_dummy != '0, s_mode_en, s_addr_en, s_cmd_en};

  function automatic state_t next_phase(input state_t cur, input logic [4:0] ena);
    next_phase = CSHOLD;
    for (int i = 5; i >= 1; i--)
      if (i > int'(cur) && ena[i-1]) next_phase = state_t'(3'(i));
  endfunction

  assign tgt = next_phase(state, en);

  always_comb begin
    ld_len  = 8'd1;
    ld_sr   = '0;
    ld_quad = 1'b1;
    ld_oe   = 4'b0000;
    case (tgt)
      CMD: begin
        ld_len  = s_cmd_quad ? 8'd2 : 8'd8;
        ld_sr   = SR_W'(s_cmd) << (SR_W - 8);
        ld_quad = s_cmd_quad;
        ld_oe   = s_cmd_quad ? 4'b1111 : 4'b0001;
      end
      ADDR: begin
        ld_len = 8'd6;
        ld_sr  = SR_W'(s_addr) << (SR_W - 24);
        ld_oe  = 4'b1111;
      end
      MODE: begin
        ld_len = 8'd2;
        ld_sr  = SR_W'(s_mode) << (SR_W - 8);
        ld_oe  = 4'b1111;
      end
      DUMMY: ld_len = 8'(s_dummy);
      DATA: begin
        ld_len = 8'(s_nbytes) << 1;
        if (s_write) begin
          ld_sr = SR_W'(s_wdata) << (SR_W - 8 * int'(s_nbytes));
          ld_oe = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  assign ld_io = ld_quad ? ld_sr[SR_W-1 -: 4] : {3'b000, ld_sr[SR_W-1]};
  assign sh_sr = quad ? (sr << 4) : (sr << 1);
  assign sh_io = quad ? sh_sr[SR_W-1 -: 4] : {3'b000, sh_sr[SR_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  div_q <= '0;  cnt <= '0;  sck <= 1'b0;  quiet <= 1'b0;
      quad <= 1'b0;  left <= '0;  sr <= '0;  hold <= '0;
      cmd_en_q <= 1'b0;  addr_en_q <= 1'b0;  mode_en_q <= 1'b0;
      cmd_quad_q <= 1'b0;  write_q <= 1'b0;  cmd_q <= '0;  mode_q <= '0;
      addr_q <= '0;  dummy_q <= '0;  nbytes_q <= '0;  wdata_q <= '0;
      bus.rdata <= '0;  bus.busy <= 1'b0;  bus.done <= 1'b0;  bus.spi_clk <= 1'b0;
      bus.spi_cs_n <= '1;  bus.spi_io_out <= '0;  bus.spi_io_oe <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          cmd_en_q <= bus.cmd_en;  addr_en_q <= bus.addr_en;  mode_en_q <= bus.mode_en;
          cmd_quad_q <= bus.cmd_quad;  write_q <= bus.write;  cmd_q <= bus.cmd;
          mode_q <= bus.mode_byte;  addr_q <= bus.addr;  dummy_q <= bus.dummy_cyc;
          nbytes_q <= bus.nbytes;  wdata_q <= bus.wdata;  div_q <= bus.clk_div;
          bus.rdata <= '0;
          bus.busy <= 1'b1;
          bus.spi_cs_n <= ~(NUM_CS'(1) << bus.cs_sel);
          cnt <= '0;  sck <= 1'b0;
          // An empty request still runs one SCK period with CS low, but keeps SCK quiet.
          state <= (tgt == CSHOLD) ? DUMMY : tgt;
          quiet <= (tgt == CSHOLD);
          left <= ld_len;  sr <= ld_sr;  quad <= ld_quad;
          bus.spi_io_oe <= ld_oe;  bus.spi_io_out <= ld_io;
        end
        CSHOLD: if (hold == '0) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          hold <= hold - 1'b1;
        end
        default: if (bus.abort) begin
          state <= CSHOLD;  hold <= HOLD_W'(CS_IDLE - 1);
          sck <= 1'b0;  bus.spi_clk <= 1'b0;  bus.spi_cs_n <= '1;
          bus.spi_io_oe <= '0;  bus.spi_io_out <= '0;
        end else if (cnt != div_q) begin
          cnt <= cnt + 1'b1;
        end else if (!sck) begin
          cnt <= '0;  sck <= 1'b1;  bus.spi_clk <= ~quiet;
          if (state == DATA && !write_q)
            bus.rdata <= {bus.rdata[RD_W-5:0], bus.spi_io_in};
        end else begin
          cnt <= '0;  sck <= 1'b0;  bus.spi_clk <= 1'b0;
          if (left != 8'd1) begin
            left <= left - 1'b1;  sr <= sh_sr;  bus.spi_io_out <= sh_io;
          end else if (tgt == CSHOLD) begin
            state <= CSHOLD;  hold <= HOLD_W'(CS_IDLE - 1);  bus.done <= 1'b1;
            bus.spi_cs_n <= '1;  bus.spi_io_oe <= '0;  bus.spi_io_out <= '0;
          end else begin
            state <= tgt;  left <= ld_len;  sr <= ld_sr;  quad <= ld_quad;
            bus.spi_io_oe <= ld_oe;  bus.spi_io_out <= ld_io;
          end
        end
      endcase
    end
  end
endmodule
